// File: rtl/gtp_fifo_pkg.sv
// Shared definitions for the GTP block FIFO: control-word field layout,
// the pad filler, block sizing and the write FSM states.
package gtp_fifo_pkg;

    localparam int MAX_IW     = 64;
    localparam int CW_LEN_LSB = 0;

    typedef enum logic {IDLE, BODY} wr_state_e;

    function automatic int cw_flag_ofs(input int iw);
        return iw - 1;
    endfunction

    function automatic int cw_chan_lsb(input int lbits);
        return lbits;
    endfunction

    function automatic int cw_chan_msb(input int iw);
        return iw - 2;
    endfunction

    // Filler for unused lanes: only the flag bit set, so it never looks like data.
    function automatic logic [MAX_IW-1:0] filler_word(input int iw);
        return MAX_IW'(1) << (iw - 1);
    endfunction

    // Storage words taken by a block whose CW announces l following words.
    function automatic int blk_words(input int l, input int ratio);
        return (l + ratio) / ratio;
    endfunction

endpackage

// File: rtl/gtp_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with
// enable, so the read data holds while the consumer stalls.
module gtp_fifo_ram #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // NOTE: no reset here -- a reset would stop the array mapping onto block RAM,
    // and nothing below the committed pointer is ever read before being written.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/gtp_block_fifo.sv
// GTP receive block FIFO: packs RATIO receiver words per storage word, commits
// whole blocks only, and streams committed words out through a FWFT register.
module gtp_block_fifo
    import gtp_fifo_pkg::*;
#(
    parameter int IW    = 16,
    parameter int RATIO = 2,
    parameter int MBITS = 13,
    parameter int LBITS = 9,
    parameter int CBITS = 6,
    parameter int CNTW  = 16
) (
    input  logic                gtp_clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [IW-1:0]       gtp_dat,
    input  logic                gtp_vld,
    output logic [IW*RATIO-1:0] out_data,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                out_sop,
    output logic                empty,
    output logic [MBITS:0]      level,
    output logic                err_ovr,
    output logic                err_undr,
    output logic                missed,
    output logic [CNTW-1:0]     missed_cnt
);

    localparam int             OW       = IW * RATIO;
    localparam int             DEPTH    = 1 << MBITS;
    localparam int             LANEW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int             FLAG     = cw_flag_ofs(IW);
    localparam logic [IW-1:0]  FILLER   = IW'(filler_word(IW));
    localparam logic [OW-1:0]  FILL_ALL = {RATIO{FILLER}};

    if ((1 + CBITS + LBITS != IW) || (IW > MAX_IW)) begin : g_cfg_check
        $error("gtp_block_fifo: 1+CBITS+LBITS must equal IW and IW must not exceed MAX_IW");
    end

    wr_state_e        r_state, w_state_nxt;
    logic [MBITS:0]   r_waddr, r_waddrb, r_raddr;
    logic [MBITS:0]   w_waddr_nxt, w_waddrb_nxt, w_used, w_put_addr, w_rd_addr;
    logic [LBITS-1:0] r_left, w_left_nxt, w_cw_len;
    logic [LANEW-1:0] r_lane, w_lane_nxt, w_put_lane;
    logic [OW-1:0]    r_pack, w_pack_nxt, w_put_base, w_wr_word;
    logic [IW-1:0]    w_put_data;
    logic             r_expect_cw, w_expect_nxt;
    logic             r_err_ovr, r_err_undr, r_missed;
    logic             w_err_ovr, w_err_undr, w_missed;
    logic [CNTW-1:0]  r_missed_cnt;
    logic             w_is_cw, w_fits, w_put, w_put_last, w_we;
    logic             r_ram_vld, r_out_vld, w_out_take, w_load, w_rd_en;
    logic [OW-1:0]    r_out_data, w_ram_rdata;

    assign w_is_cw  = gtp_dat[FLAG];
    assign w_cw_len = gtp_dat[CW_LEN_LSB +: LBITS];
    // Measured from the committed end: equals waddr in IDLE, and is the rolled-back
    // write pointer when a CW interrupts a block.
    assign w_used   = r_waddrb - r_raddr;
    assign w_fits   = (DEPTH - int'(w_used)) >= blk_words(int'(w_cw_len), RATIO);

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_waddr_nxt  = r_waddr;
        w_waddrb_nxt = r_waddrb;
        w_left_nxt   = r_left;
        w_lane_nxt   = r_lane;
        w_pack_nxt   = r_pack;
        w_expect_nxt = r_expect_cw;
        w_err_ovr    = 1'b0;
        w_err_undr   = 1'b0;
        w_missed     = 1'b0;
        w_put        = 1'b0;
        w_put_last   = 1'b0;
        w_put_base   = r_pack;
        w_put_lane   = r_lane;
        w_put_data   = gtp_dat;
        w_put_addr   = r_waddr;
        w_wr_word    = r_pack;
        w_we         = 1'b0;

        if (gtp_vld) begin
            if (w_is_cw) begin
                w_expect_nxt = 1'b0;
                if (r_state == BODY) begin
                    w_err_undr  = 1'b1;
                    w_waddr_nxt = r_waddrb;
                    w_state_nxt = IDLE;
                end
                if (w_fits) begin
                    w_put       = 1'b1;
                    w_put_base  = FILL_ALL;
                    w_put_lane  = '0;
                    w_put_addr  = r_waddrb;
                    w_put_last  = (w_cw_len == '0);
                    w_left_nxt  = w_cw_len;
                    w_state_nxt = BODY;
                end else begin
                    w_missed = 1'b1;
                end
            end else if (r_state == BODY) begin
                w_put      = 1'b1;
                w_put_data = gtp_dat & ~FILLER;
                w_put_last = (r_left == LBITS'(1));
                w_left_nxt = r_left - LBITS'(1);
            end else if (r_expect_cw) begin
                w_err_ovr    = 1'b1;
                w_expect_nxt = 1'b0;
            end
        end

        if (w_put) begin
            w_wr_word = w_put_base;
            w_wr_word[int'(w_put_lane)*IW +: IW] = w_put_data;
            w_pack_nxt  = w_wr_word;
            w_lane_nxt  = w_put_lane + LANEW'(1);
            w_waddr_nxt = w_put_addr;
            if (w_put_last || (w_put_lane == LANEW'(RATIO - 1))) begin
                w_we        = 1'b1;
                w_pack_nxt  = FILL_ALL;
                w_lane_nxt  = '0;
                w_waddr_nxt = w_put_addr + (MBITS+1)'(1);
            end
            if (w_put_last) begin
                w_waddrb_nxt = w_put_addr + (MBITS+1)'(1);
                w_state_nxt  = IDLE;
                w_expect_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge gtp_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_waddr      <= '0;
            r_waddrb     <= '0;
            r_left       <= '0;
            r_lane       <= '0;
            r_pack       <= FILL_ALL;
            r_expect_cw  <= 1'b0;
            r_err_ovr    <= 1'b0;
            r_err_undr   <= 1'b0;
            r_missed     <= 1'b0;
            r_missed_cnt <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_waddr     <= '0;
            r_waddrb    <= '0;
            r_left      <= '0;
            r_lane      <= '0;
            r_pack      <= FILL_ALL;
            r_expect_cw <= 1'b0;
            r_err_ovr   <= 1'b0;
            r_err_undr  <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_waddr     <= w_waddr_nxt;
            r_waddrb    <= w_waddrb_nxt;
            r_left      <= w_left_nxt;
            r_lane      <= w_lane_nxt;
            r_pack      <= w_pack_nxt;
            r_expect_cw <= w_expect_nxt;
            r_err_ovr   <= w_err_ovr;
            r_err_undr  <= w_err_undr;
            r_missed    <= w_missed;
            if (w_missed && (r_missed_cnt != '1)) begin
                r_missed_cnt <= r_missed_cnt + CNTW'(1);
            end
        end
    end

    // raddr advances when a word moves into the output register; the word sitting
    // in the RAM read register is still counted in level and protected from overwrite.
    assign w_rd_addr  = r_raddr + (MBITS+1)'(r_ram_vld);
    assign w_out_take = ~r_out_vld | out_rdy;
    assign w_load     = r_ram_vld & w_out_take;
    assign w_rd_en    = (w_rd_addr != r_waddrb) & (~r_ram_vld | w_load);

    always_ff @(posedge gtp_clk or negedge rst) begin
        if (!rst) begin
            r_raddr    <= '0;
            r_ram_vld  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else if (flush) begin
            r_raddr   <= '0;
            r_ram_vld <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_raddr   <= r_raddr + (MBITS+1)'(w_load);
            r_ram_vld <= w_rd_en | (r_ram_vld & ~w_load);
            r_out_vld <= w_load | (r_out_vld & ~out_rdy);
            if (w_load) begin
                r_out_data <= w_ram_rdata;
            end
        end
    end

    gtp_fifo_ram #(
        .AW (MBITS),
        .DW (OW)
    ) u_ram (
        .i_clk   (gtp_clk),
        .i_we    (w_we & ~flush),
        .i_waddr (w_put_addr[MBITS-1:0]),
        .i_wdata (w_wr_word),
        .i_re    (w_rd_en & ~flush),
        .i_raddr (w_rd_addr[MBITS-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign out_data   = r_out_data;
    assign out_vld    = r_out_vld;
    assign out_sop    = r_out_data[IW-1];
    assign level      = r_waddrb - r_raddr;
    assign empty      = (level == '0) & ~r_out_vld;
    assign err_ovr    = r_err_ovr;
    assign err_undr   = r_err_undr;
    assign missed     = r_missed;
    assign missed_cnt = r_missed_cnt;

endmodule

// File: tb/tb_gtp_block_fifo.sv
// Directed bench for gtp_block_fifo with a 16-word store: framing, padding,
// space-based drops, rollback, stray words, back-pressure, flush and reset.
module tb_gtp_block_fifo;

    logic        gtp_clk = 1'b0;
    logic        rst     = 1'b0;
    logic        flush   = 1'b0;
    logic [15:0] gtp_dat = '0;
    logic        gtp_vld = 1'b0;
    logic        out_rdy = 1'b1;
    logic [31:0] out_data;
    logic        out_vld, out_sop, empty;
    logic [4:0]  level;
    logic        err_ovr, err_undr, missed;
    logic [15:0] missed_cnt;

    int checks = 0;
    int errors = 0;

    gtp_block_fifo #(
        .IW    (16),
        .RATIO (2),
        .MBITS (4),
        .LBITS (9),
        .CBITS (6),
        .CNTW  (16)
    ) dut (
        .gtp_clk    (gtp_clk),
        .rst        (rst),
        .flush      (flush),
        .gtp_dat    (gtp_dat),
        .gtp_vld    (gtp_vld),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_sop    (out_sop),
        .empty      (empty),
        .level      (level),
        .err_ovr    (err_ovr),
        .err_undr   (err_undr),
        .missed     (missed),
        .missed_cnt (missed_cnt)
    );

    always #5 gtp_clk = ~gtp_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge gtp_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        gtp_dat = w;
        gtp_vld = 1'b1;
        tick();
        gtp_vld = 1'b0;
        gtp_dat = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_missed_cnt", missed_cnt, 0);
        chk("rst_pulses", {err_ovr, err_undr, missed}, 3'b000);
        rst = 1'b1;
        tick();

        // L=3 block: two full storage words, output 2 cycles after the commit
        send(16'h8203); send(16'h0001); send(16'h0002); send(16'h0003);
        chk("t1_level", level, 2);
        chk("t1_vld_commit", out_vld, 0);
        tick();
        chk("t1_vld_plus1", out_vld, 0);
        tick();
        chk("t1_vld_plus2", out_vld, 1);
        chk("t1_data0", out_data, 32'h0001_8203);
        chk("t1_sop0", out_sop, 1);
        tick();
        chk("t1_data1", out_data, 32'h0003_0002);
        chk("t1_sop1", out_sop, 0);
        chk("t1_vld1", out_vld, 1);
        tick();
        chk("t1_drained", out_vld, 0);
        chk("t1_empty", empty, 1);

        // L=2 block: last storage word padded with filler
        send(16'h8202);
        chk("t2_pulses_cw", {err_ovr, err_undr, missed}, 3'b000);
        send(16'h0011);
        send(16'h0012);
        chk("t2_pulses_end", {err_ovr, err_undr, missed}, 3'b000);
        tick(); tick();
        chk("t2_data0", out_data, 32'h0011_8202);
        chk("t2_sop0", out_sop, 1);
        tick();
        chk("t2_data1", out_data, 32'h8000_0012);
        chk("t2_sop1", out_sop, 0);
        tick();
        chk("t2_drained", out_vld, 0);

        // stray words after a block end
        send(16'h1234);
        chk("t5_err_ovr", err_ovr, 1);
        chk("t5_level", level, 0);
        tick();
        chk("t5_pulse_width", err_ovr, 0);
        send(16'h1235);
        chk("t5_second_stray", err_ovr, 0);
        chk("t5_empty", empty, 1);

        // CW inside a block: rollback and restart
        send(16'h8205); send(16'h00A1); send(16'h00A2);
        send(16'h8201);
        chk("t4_pulses", {err_ovr, err_undr, missed}, 3'b010);
        send(16'h0007);
        chk("t4_undr_width", err_undr, 0);
        chk("t4_level", level, 1);
        tick(); tick();
        chk("t4_vld", out_vld, 1);
        chk("t4_data", out_data, 32'h0007_8201);
        tick();
        chk("t4_no_partial", out_vld, 0);
        chk("t4_empty", empty, 1);

        // fill to 14 unread, then a block needing 3 words is dropped
        out_rdy = 1'b0;
        for (int b = 0; b < 3; b++) begin
            send(16'h8209);
            for (int i = 1; i <= 9; i++) send(16'(i));
        end
        repeat (3) tick();
        chk("t3_level_full", level, 14);
        chk("t3_head", out_data, 32'h0001_8209);
        chk("t3_head_vld", out_vld, 1);
        chk("t3_not_empty", empty, 0);
        send(16'h8205);
        chk("t3_missed", missed, 1);
        chk("t3_missed_cnt", missed_cnt, 1);
        chk("t3_level_after_miss", level, 14);
        send(16'h8201);
        chk("t3_missed_width", missed, 0);
        send(16'h0042);
        chk("t3_level_small", level, 15);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_level", level, 0);
        chk("fl_vld", out_vld, 0);
        chk("fl_empty", empty, 1);
        chk("fl_missed_cnt", missed_cnt, 1);

        // back-pressure with 3 committed words
        send(16'h8203); send(16'h0001); send(16'h0002); send(16'h0003);
        send(16'h8201); send(16'h0005);
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_data", out_data, 32'h0001_8203);
            chk("t6_hold_vld", out_vld, 1);
            chk("t6_level", level, 2);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        chk("t6_data1", out_data, 32'h0003_0002);
        tick();
        chk("t6_data2", out_data, 32'h0005_8201);
        chk("t6_sop2", out_sop, 1);
        tick();
        chk("t6_drained", out_vld, 0);
        chk("t6_empty", empty, 1);

        // asynchronous reset in the middle of a block
        out_rdy = 1'b0;
        send(16'h8201); send(16'h0009);
        tick(); tick();
        chk("r_vld_before", out_vld, 1);
        send(16'h8203); send(16'h0001);
        #2 rst = 1'b0;
        #1;
        chk("r_vld", out_vld, 0);
        chk("r_empty", empty, 1);
        chk("r_level", level, 0);
        chk("r_missed_cnt", missed_cnt, 0);
        tick();
        rst = 1'b1;
        out_rdy = 1'b1;
        send(16'h1111);
        chk("r_no_ovr", err_ovr, 0);
        send(16'h8201); send(16'h0008);
        tick(); tick();
        chk("r_data", out_data, 32'h0008_8201);
        chk("r_data_vld", out_vld, 1);
        tick();
        chk("r_drained", out_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gtp_block_fifo.md
Name: gtp_block_fifo

Overview:
- Parametrised successor of the GTP receive block FIFO: accepts IW-bit receiver words framed as blocks, each headed by a control word (CW), packs RATIO words per storage word, and commits only whole blocks.
- New over the previous generation: generic widths and depth, a valid/ready output stream with a start-of-block flag, and rollback of partially written blocks on framing errors.
- Also adds a flush, a committed-level output and a saturating missed-block counter.
- Sits between the GTP receiver and the MIG arbiter, entirely in the gtp_clk domain.

Parameters:
- IW, 16: input word width.
- RATIO, 2: input words per storage word; OW = IW*RATIO.
- MBITS, 13: log2 of storage depth in OW words.
- LBITS, 9: CW length field width.
- CBITS, 6: CW channel field width; elaboration check that 1+CBITS+LBITS == IW.
- CNTW, 16: width of the missed-block counter.

Ports:
- gtp_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous: discard all stored and partial data.
- gtp_dat  in  IW  receiver word.
- gtp_vld  in  1  gtp_dat valid.
- out_data  out  OW  storage word; lane 0 = earliest input word.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  consumer accepts out_data.
- out_sop  out  1  out_data is the first word of a block (= out_data[IW-1]).
- empty  out  1  no committed words in storage or output register.
- level  out  MBITS+1  committed storage words not yet fetched.
- err_ovr  out  1  pulse: non-CW received where a CW was required.
- err_undr  out  1  pulse: CW received inside a block.
- missed  out  1  pulse: block dropped for lack of space.
- missed_cnt  out  CNTW  saturating count of dropped blocks.

Behaviour:
- CW format: bit IW-1 = 1, channel [IW-2:LBITS], L = [LBITS-1:0] = words following the CW.
- Block words other than the CW have bit IW-1 cleared on write.
- Block length: N = L+1 input words, occupying S = ceil(N/RATIO) storage words.
- Padding: unused lanes of the last storage word are filled with filler 1<<(IW-1).
- Pointers: waddr (write), waddrb (committed end), raddr (fetch); all MBITS+1 bits, wrap naturally. Full capacity is 2^MBITS words.
- Free space = 2^MBITS - (waddr - raddr).
- Write FSM states:
  - IDLE: on CW with free >= S, go to BODY, load L, store the CW in lane 0. On CW with insufficient space, pulse missed, increment missed_cnt (saturate at all ones) and stay in IDLE. A non-CW is dropped silently, except the first valid word after a block end, which also pulses err_ovr.
  - BODY: pack words into lanes. Write storage when the lane is full or when the block ends; at block end set waddrb = waddr+1 and go to IDLE with the expect-CW flag set.
  - CW seen in BODY: pulse err_undr, roll back waddr <= waddrb, then evaluate this CW as in IDLE in the same cycle.
- Visibility: only words below waddrb are ever fetched; a partial block is never visible. Commit and fetch in the same cycle are both honoured.
- Read path: 1-cycle synchronous RAM read feeding one output register (first-word fall-through).
  - out_vld rises 2 cycles after the commit cycle when previously empty.
  - Transfer occurs when out_vld & out_rdy; a new word may follow every cycle at full rate.
  - While out_vld & ~out_rdy, out_data, out_sop and out_vld hold stable.
- level = waddrb - raddr. empty = (level == 0) & ~out_vld.
- Error pulses are 1 cycle wide and mutually exclusive except err_undr+missed, which may pulse together.
- flush (higher priority than all data events): all pointers to 0, FSM to IDLE, out_vld 0, expect-CW flag cleared. missed_cnt is retained.
- rst low (asynchronous): all pointers, FSM, out_vld, error pulses, missed_cnt and the expect-CW flag are 0. A partial block is lost. Outputs are stable from the first edge after release.
- Storage contents are not reset.

Decomposition:
- Package gtp_fifo_pkg holds:
  - CW field offsets derived from IW/CBITS/LBITS;
  - FILLER constant;
  - function blk_words(L, RATIO) = ceil((L+1)/RATIO);
  - FSM state enum {IDLE, BODY}.
- Natural sub-module: gtp_fifo_ram, a simple dual-port RAM (write port, registered read port) of 2^MBITS x OW, inferable as block RAM.

Test Plan (IW=16, RATIO=2, MBITS=4, LBITS=9, CBITS=6):
- CW 0x8203 (L=3) + words 0x0001, 0x0002, 0x0003, out_rdy=1 -> two words 0x00018203 then 0x00030002, out_sop=1 on the first only; out_vld rises 2 cycles after the last write.
- CW 0x8202 + 0x0011, 0x0012 -> 0x00118202 then 0x80000012 (filler); no error pulses.
- With 14 words committed and unread, CW 0x8205 (S=3) -> missed=1, missed_cnt=1, no write. A following CW 0x8201 (S=1) is accepted.
- CW 0x8205, two body words, then CW 0x8201 + 0x0007 -> err_undr=1; partial block rolled back; output shows only 0x00078201; level=1.
- After a block ends, word 0x1234 -> err_ovr=1 and the word is dropped. A second stray word gives no pulse.
- out_rdy=0 for 5 cycles with 3 words committed -> out_data held, level=2. rst low mid-block -> out_vld=0, empty=1, missed_cnt=0.
